// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Responder side of the CPU data_sram port. Every cycle it can take one request
// from the MEM stage and returns read data registered on the same edge, so the
// CPU sees it during the following cycle (block-RAM style, one-cycle latency).
//
// Address map:
//   addr[31:16] == CONF_BASE_HI : config window (offset = addr[15:0])
//     0x0000 LED        RW  [15:0], byte-enabled, upper bits read 0
//     0x0004 SWITCH     RO  synchronised switch value, zero-extended
//     0x0008 TIMER      RW  free-running 32-bit counter
//     0x000C TIMER_CMP  RW  compare value (0 disables the match)
//     0x0010 STATUS     bit0 = timer_irq, write 1 to bit0 clears it
//     other offsets read 0 and ignore writes
//   anything else               : data RAM, word index addr[ADDR_W+1:2]
//                                 (upper bits ignored, so the RAM aliases)
//
// Ports:
//   clk              clock
//   resetn           synchronous, active-low reset
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables, 0 = read
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  write data
//   data_sram_rdata  read data, valid the cycle after the request
//   switch           raw board switches (asynchronous)
//   led              LED register
//   timer_irq        sticky timer compare-match interrupt
// -----------------------------------------------------------------------------
module data_sram_responder #(
   parameter int          ADDR_W       = 8,
   parameter logic [15:0] CONF_BASE_HI = 16'hBFAF,
   parameter int          SW_W         = 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            data_sram_en,
   input  logic [3:0]      data_sram_wen,
   input  logic [31:0]     data_sram_addr,
   input  logic [31:0]     data_sram_wdata,
   output logic [31:0]     data_sram_rdata,
   input  logic [SW_W-1:0] switch,
   output logic [15:0]     led,
   output logic            timer_irq
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Config register word offsets (addr[15:2]).
   localparam logic [13:0] OFF_LED    = 14'h0000;
   localparam logic [13:0] OFF_SWITCH = 14'h0001;
   localparam logic [13:0] OFF_TIMER  = 14'h0002;
   localparam logic [13:0] OFF_CMP    = 14'h0003;
   localparam logic [13:0] OFF_STATUS = 14'h0004;

   // Replace the bytes of old_val selected by be with the matching bytes of new_val.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     rdata_q,   rdata_d;
   logic [15:0]     led_q,     led_d;
   logic [31:0]     timer_q,   timer_d;
   logic [31:0]     cmp_q,     cmp_d;
   logic            irq_q,     irq_d;
   logic [SW_W-1:0] sw_meta_q;
   logic [SW_W-1:0] sw_sync_q;

   // -------------------------------------------------------------------------
   // Decode
   // -------------------------------------------------------------------------
   logic              is_conf;
   logic [13:0]       conf_word;
   logic [ADDR_W-1:0] ram_idx;
   logic              req_wr;
   logic              ram_we;
   logic              led_we;
   logic              timer_we;
   logic              cmp_we;
   logic              status_clr;
   logic              irq_match;
   logic [31:0]       conf_rdata;
   logic [31:0]       ram_rdata;
   logic [31:0]       ram_wdata;

   assign is_conf   = (data_sram_addr[31:16] == CONF_BASE_HI);
   assign conf_word = data_sram_addr[15:2];
   assign ram_idx   = data_sram_addr[ADDR_W+1:2];
   assign req_wr    = data_sram_en && (data_sram_wen != 4'b0000);

   assign ram_we     = req_wr && !is_conf;
   assign led_we     = req_wr && is_conf && (conf_word == OFF_LED);
   assign timer_we   = req_wr && is_conf && (conf_word == OFF_TIMER);
   assign cmp_we     = req_wr && is_conf && (conf_word == OFF_CMP);
   assign status_clr = req_wr && is_conf && (conf_word == OFF_STATUS)
                       && data_sram_wen[0] && data_sram_wdata[0];

   // Address bits [1:0] are byte-lane bits; the word port ignores them.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^data_sram_addr[1:0];

   // -------------------------------------------------------------------------
   // Read path: all sources are the values held before this edge, which gives
   // read-first behaviour for the RAM and for every config register.
   // -------------------------------------------------------------------------
   assign ram_rdata = mem_q[ram_idx];
   assign ram_wdata = byte_merge(ram_rdata, data_sram_wdata, data_sram_wen);

   always_comb begin
      conf_rdata = 32'h0;
      case (conf_word)
         OFF_LED:    conf_rdata = {16'h0, led_q};
         OFF_SWITCH: conf_rdata = 32'(sw_sync_q);
         OFF_TIMER:  conf_rdata = timer_q;
         OFF_CMP:    conf_rdata = cmp_q;
         OFF_STATUS: conf_rdata = {31'h0, irq_q};
         default:    conf_rdata = 32'h0;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (data_sram_en) begin
         rdata_d = is_conf ? conf_rdata : ram_rdata;
      end
   end

   // -------------------------------------------------------------------------
   // Config register next-state
   // -------------------------------------------------------------------------
   always_comb begin
      led_d = led_q;
      if (led_we) begin
         if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
         if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
      end
   end

   // A TIMER write replaces that cycle's increment; counting resumes next cycle.
   always_comb begin
      timer_d = timer_q + 32'd1;
      if (timer_we) begin
         timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
      end
   end

   always_comb begin
      cmp_d = cmp_q;
      if (cmp_we) begin
         cmp_d = byte_merge(cmp_q, data_sram_wdata, data_sram_wen);
      end
   end

   // Match uses the current timer/compare values; a simultaneous set beats a clear.
   assign irq_match = (timer_q == cmp_q) && (cmp_q != 32'h0);

   always_comb begin
      irq_d = irq_q;
      if (status_clr) irq_d = 1'b0;
      if (irq_match)  irq_d = 1'b1;
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_q   <= 32'h0;
         led_q     <= 16'h0;
         timer_q   <= 32'h0;
         cmp_q     <= 32'h0;
         irq_q     <= 1'b0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         timer_q   <= timer_d;
         cmp_q     <= cmp_d;
         irq_q     <= irq_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
      end
   end

   // RAM contents are not reset, but a write seen during reset is dropped.
   always_ff @(posedge clk) begin
      if (resetn && ram_we) begin
         mem_q[ram_idx] <= ram_wdata;
      end
   end

   assign data_sram_rdata = rdata_q;
   assign led             = led_q;
   assign timer_irq       = irq_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

   localparam int          ADDR_W = 8;
   localparam int          SW_W   = 8;
   localparam logic [15:0] HI     = 16'hBFAF;
   localparam logic [31:0] C_LED  = 32'hBFAF0000;
   localparam logic [31:0] C_SW   = 32'hBFAF0004;
   localparam logic [31:0] C_TMR  = 32'hBFAF0008;
   localparam logic [31:0] C_CMP  = 32'hBFAF000C;
   localparam logic [31:0] C_STA  = 32'hBFAF0010;

   logic            clk = 1'b0;
   logic            resetn;
   logic            en;
   logic [3:0]      wen;
   logic [31:0]     addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic [SW_W-1:0] sw;
   logic [15:0]     led;
   logic            irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_sram_responder #(.ADDR_W(ADDR_W), .CONF_BASE_HI(HI), .SW_W(SW_W)) dut (
      .clk(clk), .resetn(resetn),
      .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_rdata(rdata),
      .switch(sw), .led(led), .timer_irq(irq)
   );

   // ---------------- reference model (register-map level) ----------------
   logic [31:0]     m_mem [2**ADDR_W];
   logic [31:0]     m_rdata = 0;
   logic [15:0]     m_led   = 0;
   logic [31:0]     m_timer = 0;
   logic [31:0]     m_cmp   = 0;
   logic            m_irq   = 0;
   logic [SW_W-1:0] m_sw1   = 0;
   logic [SW_W-1:0] m_sw2   = 0;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:16] != HI) return m_mem[a[ADDR_W+1:2]];
      case ({a[15:2], 2'b00})
         16'h0000: return {16'h0, m_led};
         16'h0004: return {24'h0, m_sw2};
         16'h0008: return m_timer;
         16'h000C: return m_cmp;
         16'h0010: return {31'h0, m_irq};
         default:  return 32'h0;
      endcase
   endfunction

   // One clock edge of the register map, using the inputs present at the edge.
   task automatic model_edge();
      logic        hit;
      logic        clr;
      logic [31:0] nt;
      logic [15:0] off;
      if (!resetn) begin
         m_rdata = 0; m_led = 0; m_timer = 0; m_cmp = 0; m_irq = 0; m_sw1 = 0; m_sw2 = 0;
         return;
      end
      hit = (m_timer == m_cmp) && (m_cmp != 0);
      clr = 1'b0;
      nt  = m_timer + 1;
      off = {addr[15:2], 2'b00};
      if (en) m_rdata = model_read(addr);
      if (en && wen != 0) begin
         if (addr[31:16] == HI) begin
            if (off == 16'h0000) m_led = merge({16'h0, m_led}, wdata, wen & 4'b0011);
            if (off == 16'h0008) nt = merge(m_timer, wdata, wen);
            if (off == 16'h000C) m_cmp = merge(m_cmp, wdata, wen);
            if (off == 16'h0010) clr = wen[0] & wdata[0];
         end else begin
            m_mem[addr[ADDR_W+1:2]] = merge(m_mem[addr[ADDR_W+1:2]], wdata, wen);
         end
      end
      m_timer = nt;
      m_irq   = hit | (m_irq & ~clr);
      m_sw2   = m_sw1;
      m_sw1   = sw;
   endtask

   // Present one request, take one clock edge, return 1 time unit after it.
   task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
      en = e; wen = w; addr = a; wdata = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   // ---------------------------- tests ----------------------------
   task automatic test_reset();
      resetn = 1'b0;
      idle(); idle();
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      resetn = 1'b1;
      drive(1'b1, 4'h0, C_TMR, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_timer0: got %h want %h", rdata, 32'h0); end
      drive(1'b1, 4'h0, C_TMR, 32'h0);
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL reset_timer1: got %h want %h", rdata, 32'h1); end
   endtask

   task automatic test_ram_basic();
      drive(1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF);
      drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_read: got %h want %h", rdata, 32'hDEADBEEF); end
      for (int i = 0; i < 2; i++) begin
         idle();
         checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_hold: got %h want %h", rdata, 32'hDEADBEEF); end
      end
   endtask

   task automatic test_partial_write();
      drive(1'b1, 4'hF, 32'h0000_0020, 32'h11223344);
      drive(1'b1, 4'b0101, 32'h0000_0020, 32'hAABBCCDD);
      checks++; if (rdata !== 32'h11223344) begin errors++; $display("FAIL read_first: got %h want %h", rdata, 32'h11223344); end
      drive(1'b1, 4'h0, 32'h0000_0020, 32'h0);
      checks++; if (rdata !== 32'h11BB33DD) begin errors++; $display("FAIL partial_write: got %h want %h", rdata, 32'h11BB33DD); end
   endtask

   task automatic test_alias();
      drive(1'b1, 4'hF, 32'h0000_0400, 32'h5);
      drive(1'b1, 4'h0, 32'h0000_0000, 32'h0);
      checks++; if (rdata !== 32'h5) begin errors++; $display("FAIL alias: got %h want %h", rdata, 32'h5); end
   endtask

   task automatic test_config();
      drive(1'b1, 4'hF, C_LED, 32'hFFFF1234);
      checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_out: got %h want %h", led, 16'h1234); end
      drive(1'b1, 4'h0, C_LED, 32'h0);
      checks++; if (rdata !== 32'h00001234) begin errors++; $display("FAIL led_read: got %h want %h", rdata, 32'h00001234); end
      sw = 8'hA5;
      idle(); idle();
      drive(1'b1, 4'h0, C_SW, 32'h0);
      checks++; if (rdata !== 32'h000000A5) begin errors++; $display("FAIL switch_read: got %h want %h", rdata, 32'h000000A5); end
      drive(1'b1, 4'hF, 32'hBFAF0020, 32'hFFFFFFFF);
      drive(1'b1, 4'h0, 32'hBFAF0020, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want %h", rdata, 32'h0); end
      checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_keep: got %h want %h", led, 16'h1234); end
   endtask

   task automatic test_timer_wrap();
      logic [31:0] exp [3];
      exp[0] = 32'hFFFFFFFE; exp[1] = 32'hFFFFFFFF; exp[2] = 32'h0;
      drive(1'b1, 4'hF, C_TMR, 32'hFFFFFFFE);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'h0, C_TMR, 32'h0);
         checks++; if (rdata !== exp[i]) begin errors++; $display("FAIL timer_wrap[%0d]: got %h want %h", i, rdata, exp[i]); end
      end
   endtask

   task automatic test_irq();
      // Compare value 0 never matches, even as the timer passes through 0.
      drive(1'b1, 4'hF, C_CMP, 32'h0);
      drive(1'b1, 4'h1, C_STA, 32'h1);
      drive(1'b1, 4'hF, C_TMR, 32'hFFFFFFFD);
      for (int i = 0; i < 6; i++) idle();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cmp0: got %b want 0", irq); end
      // Compare 100, timer loaded with 90: flag rises 11 edges after the write.
      drive(1'b1, 4'hF, C_TMR, 32'h0);
      drive(1'b1, 4'hF, C_CMP, 32'd100);
      drive(1'b1, 4'h1, C_STA, 32'h1);
      drive(1'b1, 4'hF, C_TMR, 32'd90);
      for (int k = 1; k <= 11; k++) begin
         idle();
         checks++;
         if (irq !== (k == 11)) begin errors++; $display("FAIL irq_rise[%0d]: got %b want %b", k, irq, (k == 11)); end
      end
      drive(1'b1, 4'h0, C_STA, 32'h0);
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL status_read: got %h want %h", rdata, 32'h1); end
      drive(1'b1, 4'h1, C_STA, 32'h1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
      // Clear presented in the match cycle: set wins.
      drive(1'b1, 4'hF, C_TMR, 32'd98);
      idle(); idle();
      drive(1'b1, 4'h1, C_STA, 32'h1);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq); end
      idle();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b want 1", irq); end
      drive(1'b1, 4'h1, C_STA, 32'h1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear2: got %b want 0", irq); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [15:0] offs [7];
      offs[0] = 16'h0000; offs[1] = 16'h0004; offs[2] = 16'h0008; offs[3] = 16'h000C;
      offs[4] = 16'h0010; offs[5] = 16'h0020; offs[6] = 16'h0014;
      for (int i = 0; i < 2**ADDR_W; i++) drive(1'b1, 4'hF, 32'(i) << 2, $urandom);
      drive(1'b1, 4'h0, 32'h0, 32'h0);
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            a = $urandom;
            if (a[31:16] == HI) a[16] = ~a[16];
         end else begin
            a = {HI, offs[$urandom_range(0, 6)] | 16'($urandom_range(0, 3))};
         end
         sw = SW_W'($urandom);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)),
               a, $urandom);
         checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rdata, m_rdata); end
         checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led[%0d]: got %h want %h", n, led, m_led); end
         checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", n, irq, m_irq); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] keep;
      keep = m_mem[16];
      drive(1'b1, 4'hF, C_LED, 32'h0000BEEF);
      drive(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      checks++; if (rdata !== keep) begin errors++; $display("FAIL pre_reset_read: got %h want %h", rdata, keep); end
      resetn = 1'b0;
      drive(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_read_drop: got %h want %h", rdata, 32'h0); end
      drive(1'b1, 4'hF, C_LED, 32'h00005555);
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led_write: got %h want %h", led, 16'h0); end
      drive(1'b1, 4'hF, 32'h0000_0040, 32'h12345678);
      resetn = 1'b1;
      drive(1'b1, 4'h0, C_TMR, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_timer: got %h want %h", rdata, 32'h0); end
      drive(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      checks++; if (rdata !== keep) begin errors++; $display("FAIL reset_ram_write: got %h want %h", rdata, keep); end
   endtask

   initial begin
      resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = '0;
      for (int i = 0; i < 2**ADDR_W; i++) m_mem[i] = 32'h0;
      test_reset();
      test_ram_basic();
      test_partial_write();
      test_alias();
      test_config();
      test_timer_wrap();
      test_irq();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
